soc_system_led_driver: RTL

- Downstream stage of the LED PIO. Takes the 8-bit LED pattern that the PIO drives and produces the physical LED pins.
- Adds global PWM brightness, optional blink, and polarity inversion, all configured through a small Avalon-MM slave on the HPS lightweight bridge.
- Sits between the PIO `out_port` and the top-level LED pins.

---
 rtl/soc_system_led_pkg.sv | 27 ++
 rtl/soc_system_led_timebase.sv | 36 +++
 rtl/soc_system_led_driver.sv | 127 ++++++++++++
 3 files changed

// File: rtl/soc_system_led_pkg.sv
// Shared constants and types for the LED driver: register map, CTRL/STATUS
// bit positions and register reset values.
package soc_system_led_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DUTY   = 2'd1;
  localparam logic [1:0] ADDR_BLINK  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_BLINK_EN = 1;
  localparam int CTRL_INVERT   = 2;

  localparam int STATUS_PHASE  = 8;
  localparam int STATUS_CHANGE = 9;

  // Field order mirrors the CTRL bit indices above (MSB first).
  typedef struct packed {
    logic invert;
    logic blink_en;
    logic enable;
  } ctrl_t;

  localparam ctrl_t      CTRL_RST = '{invert: 1'b0, blink_en: 1'b0, enable: 1'b1};
  localparam logic [7:0] DUTY_RST = 8'h80;

endpackage

// File: rtl/soc_system_led_timebase.sv
// PWM timebase: a prescaler producing one step every PRESCALE clocks and an
// 8-bit PWM counter; a frame is the step that wraps the counter.
module soc_system_led_timebase #(
  parameter int PRESCALE = 196
) (
  input  logic       clk,
  input  logic       reset,
  output logic       o_step,
  output logic       o_frame,
  output logic [7:0] o_pwm_cnt
);

  localparam int              PW   = $clog2(PRESCALE);
  localparam logic [PW-1:0]   TERM = PW'(PRESCALE - 1);

  logic [PW-1:0] r_presc;
  logic [7:0]    r_pwm_cnt;

  assign o_step    = (r_presc == TERM);
  assign o_frame   = o_step && (r_pwm_cnt == 8'hFF);
  assign o_pwm_cnt = r_pwm_cnt;

  // NOTE: state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc   <= '0;
      r_pwm_cnt <= '0;
    end else if (o_step) begin
      r_presc   <= '0;
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
    end else begin
      r_presc   <= r_presc + 1'b1;
    end
  end

endmodule

// File: rtl/soc_system_led_driver.sv
// LED driver between the PIO pattern and the LED pins: PWM brightness with a
// frame-synchronous duty shadow, optional blink and polarity inversion.
module soc_system_led_driver
  import soc_system_led_pkg::*;
#(
  parameter int PRESCALE  = 196,
  parameter int BLINK_RST = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  pattern_in,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  led_out
);

  logic       w_step;
  logic       w_frame;
  logic [7:0] w_pwm_cnt;

  soc_system_led_timebase #(.PRESCALE(PRESCALE)) u_timebase (
    .clk      (clk),
    .reset    (reset),
    .o_step   (w_step),
    .o_frame  (w_frame),
    .o_pwm_cnt(w_pwm_cnt)
  );

  ctrl_t       r_ctrl;
  logic [7:0]  r_duty_req;
  logic [7:0]  r_duty_act;
  logic [15:0] r_blink;
  logic [15:0] r_blink_cnt;
  logic        r_phase;
  logic [7:0]  r_pattern_q;
  logic        r_change_seen;
  logic [7:0]  r_led_out;

  logic w_wr;
  logic w_wr_ctrl;
  logic w_wr_duty;
  logic w_wr_blink;
  logic w_wr_status;
  logic w_pwm_on;
  logic w_gate;
  logic w_unused;

  assign w_wr        = chipselect && !write_n;
  assign w_wr_ctrl   = w_wr && (address == ADDR_CTRL);
  assign w_wr_duty   = w_wr && (address == ADDR_DUTY);
  assign w_wr_blink  = w_wr && (address == ADDR_BLINK);
  assign w_wr_status = w_wr && (address == ADDR_STATUS);
  assign w_unused    = ^{writedata[31:16], w_step};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl     <= CTRL_RST;
      r_duty_req <= DUTY_RST;
      r_duty_act <= DUTY_RST;
      r_blink    <= 16'(BLINK_RST);
    end else begin
      if (w_wr_ctrl)  r_ctrl     <= ctrl_t'(writedata[2:0]);
      if (w_wr_duty)  r_duty_req <= writedata[7:0];
      // Duty only takes effect at a frame boundary so a frame is never split.
      if (w_frame)    r_duty_act <= r_duty_req;
      if (w_wr_blink) r_blink    <= writedata[15:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (w_wr_blink || (r_blink == 16'd0)) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (w_frame) begin
      if (r_blink_cnt == r_blink - 16'd1) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 16'd1;
      end
    end
  end

  assign w_pwm_on = (r_duty_act == 8'hFF) || (w_pwm_cnt < r_duty_act);
  assign w_gate   = r_ctrl.enable && w_pwm_on && (!r_ctrl.blink_en || r_phase);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pattern_q   <= '0;
      r_change_seen <= 1'b0;
      r_led_out     <= '0;
    end else begin
      r_pattern_q <= pattern_in;
      // A new change outranks a simultaneous W1C clear.
      if (pattern_in != r_pattern_q)
        r_change_seen <= 1'b1;
      else if (w_wr_status && writedata[STATUS_CHANGE])
        r_change_seen <= 1'b0;
      r_led_out <= ({8{w_gate}} & r_pattern_q) ^ {8{r_ctrl.invert}};
    end
  end

  assign led_out = r_led_out;

  // NOTE: the default before the case keeps this always_comb latch-free.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL:   readdata[2:0]  = r_ctrl;
      ADDR_DUTY:   readdata[7:0]  = r_duty_req;
      ADDR_BLINK:  readdata[15:0] = r_blink;
      ADDR_STATUS: begin
        readdata[7:0]          = r_led_out;
        readdata[STATUS_PHASE]  = r_phase;
        readdata[STATUS_CHANGE] = r_change_seen;
      end
      default:     readdata = '0;
    endcase
  end

endmodule
